boot_loader: RTL and testbench

//  Writer side of the boot memory. Receives a byte stream over a valid/ready handshake,

---
 rtl/boot_loader.sv | 166 ++++++++++++++++
 tb/tb_boot_loader.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/boot_loader.sv
// Boot image loader: packs a little-endian byte stream into 32-bit words, writes them to boot memory
// and releases the CPU once the image is in. Optional trailing checksum check via `define CHECKSUM_EN.
module boot_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic [31:0] mem_address,
  output logic [31:0] mem_data,
  output logic        mem_write,
  output logic        cpu_hold,
  output logic        done,
  output logic        error
);

  localparam int unsigned IW = $clog2(MAX_WORDS + 1);

`ifdef CHECKSUM_EN
  typedef enum logic [2:0] {S_LEN, S_DATA, S_WR, S_CSUM, S_DONE, S_ERR} state_e;
`else
  typedef enum logic [2:0] {S_LEN, S_DATA, S_WR, S_DONE, S_ERR} state_e;
`endif

  state_e         state_q;
  logic [1:0]     bcnt_q;
  logic [23:0]    shift_q;
  logic [IW-1:0]  n_q;
  logic [IW-1:0]  idx_q;
  logic           byte_ready_q;
  logic [31:0]    mem_address_q;
  logic [31:0]    mem_data_q;
  logic           mem_write_q;
  logic           cpu_hold_q;
  logic           done_q;
  logic           error_q;
`ifdef CHECKSUM_EN
  logic [31:0]    sum_q;
`endif

  logic           accept_d;
  logic           last_d;
  logic [31:0]    word_d;
  logic [IW-1:0]  idx_inc_d;

  // The three earlier bytes of the group sit in shift_q, oldest in the low byte.
  assign accept_d  = byte_valid & byte_ready_q;
  assign last_d    = accept_d & (bcnt_q == 2'd3);
  assign word_d    = {byte_in, shift_q};
  assign idx_inc_d = idx_q + IW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_LEN;
      bcnt_q        <= 2'd0;
      shift_q       <= 24'd0;
      n_q           <= '0;
      idx_q         <= '0;
      byte_ready_q  <= 1'b0;
      mem_address_q <= BASE_ADDR;
      mem_data_q    <= 32'd0;
      mem_write_q   <= 1'b0;
      cpu_hold_q    <= 1'b1;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
`ifdef CHECKSUM_EN
      sum_q         <= 32'd0;
`endif
    end else begin
      mem_write_q <= 1'b0;
      if (accept_d) begin
        shift_q <= word_d[31:8];
        bcnt_q  <= bcnt_q + 2'd1;
      end
      case (state_q)
        S_LEN: begin
          byte_ready_q <= 1'b1;
          if (last_d) begin
            if (word_d > 32'(MAX_WORDS)) begin
              state_q      <= S_ERR;
              byte_ready_q <= 1'b0;
              error_q      <= 1'b1;
            end else if (word_d == 32'd0) begin
`ifdef CHECKSUM_EN
              state_q      <= S_CSUM;
`else
              state_q      <= S_DONE;
              byte_ready_q <= 1'b0;
              done_q       <= 1'b1;
              cpu_hold_q   <= 1'b0;
`endif
            end else begin
              n_q     <= word_d[IW-1:0];
              state_q <= S_DATA;
            end
          end
        end
        S_DATA: begin
          byte_ready_q <= 1'b1;
          if (last_d) begin
            state_q       <= S_WR;
            byte_ready_q  <= 1'b0;
            mem_write_q   <= 1'b1;
            mem_data_q    <= word_d;
            mem_address_q <= BASE_ADDR + (32'(idx_q) << 2);
`ifdef CHECKSUM_EN
            sum_q         <= sum_q + word_d;
`endif
          end
        end
        S_WR: begin
          idx_q <= idx_inc_d;
          if (idx_inc_d < n_q) begin
            state_q      <= S_DATA;
            byte_ready_q <= 1'b1;
          end else begin
`ifdef CHECKSUM_EN
            state_q      <= S_CSUM;
            byte_ready_q <= 1'b1;
`else
            state_q      <= S_DONE;
            byte_ready_q <= 1'b0;
            done_q       <= 1'b1;
            cpu_hold_q   <= 1'b0;
`endif
          end
        end
`ifdef CHECKSUM_EN
        S_CSUM: begin
          byte_ready_q <= 1'b1;
          if (last_d) begin
            byte_ready_q <= 1'b0;
            if (word_d == sum_q) begin
              state_q    <= S_DONE;
              done_q     <= 1'b1;
              cpu_hold_q <= 1'b0;
            end else begin
              state_q <= S_ERR;
              error_q <= 1'b1;
            end
          end
        end
`endif
        S_DONE: byte_ready_q <= 1'b0;
        S_ERR:  byte_ready_q <= 1'b0;
        default: begin
          state_q      <= S_ERR;
          byte_ready_q <= 1'b0;
          error_q      <= 1'b1;
        end
      endcase
    end
  end

  assign byte_ready  = byte_ready_q;
  assign mem_address = mem_address_q;
  assign mem_data    = mem_data_q;
  assign mem_write   = mem_write_q;
  assign cpu_hold    = cpu_hold_q;
  assign done        = done_q;
  assign error       = error_q;

endmodule

// File: tb/tb_boot_loader.sv
// Scoreboard bench for boot_loader: expected memory writes are queued as each image is issued
// and a negedge monitor pops them against every mem_write pulse.
module tb_boot_loader;
  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam int          MAXW = 1024;

  logic        clk, rst, byte_valid, byte_ready, mem_write, cpu_hold, done, error;
  logic [7:0]  byte_in;
  logic [31:0] mem_address, mem_data;

  typedef struct packed {logic [31:0] a; logic [31:0] d;} wr_t;
  wr_t         exp_q[$];
  logic [31:0] img_q[$];
  logic [7:0]  bytes_q[$];
  int          tests = 0, fails = 0, wr_cnt = 0;
  logic        wr_prev = 1'b0;

  boot_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
    .clk(clk), .rst(rst), .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .mem_address(mem_address), .mem_data(mem_data), .mem_write(mem_write),
    .cpu_hold(cpu_hold), .done(done), .error(error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the oldest outstanding expected write.
  always @(negedge clk) begin
    wr_t e;
    if (mem_write === 1'b1) begin
      wr_cnt++;
      chk("wr_single_cycle", {31'd0, wr_prev}, 32'd0);
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write: addr %h data %h, expected no write", mem_address, mem_data);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", mem_address, e.a);
        chk("wr_data", mem_data, e.d);
      end
    end
    wr_prev = mem_write;
  end

  task automatic do_reset(input int cyc);
    rst = 1'b1;
    byte_valid = 1'b0;
    repeat (cyc) @(negedge clk);
    chk("rst_cpu_hold", {31'd0, cpu_hold}, 32'd1);
    chk("rst_byte_ready", {31'd0, byte_ready}, 32'd0);
    chk("rst_mem_write", {31'd0, mem_write}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_error", {31'd0, error}, 32'd0);
    chk("rst_mem_address", mem_address, BASE);
    chk("rst_mem_data", mem_data, 32'd0);
    exp_q.delete();
    wr_cnt = 0;
    rst = 1'b0;
  endtask

  // Offer one byte after an idle gap; returns at the negedge after it is accepted.
  task automatic put(input logic [7:0] b, input int gap);
    int   n;
    logic rdy;
    n = 0;
    repeat (gap) begin
      byte_valid = 1'b0;
      @(negedge clk);
    end
    byte_in = b;
    byte_valid = 1'b1;
    forever begin
      rdy = byte_ready;
      @(negedge clk);
      if (rdy) break;
      n++;
      if (n > 50) begin
        tests++;
        fails++;
        $display("FAIL put_timeout: byte %h, byte_ready 0 for %0d cycles, expected 1", b, n);
        break;
      end
    end
  endtask

  task automatic end_check(input bit exp_done, input int exp_writes);
    int n;
    n = 0;
    while (!(done || error) && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk("end_done", {31'd0, done}, {31'd0, exp_done});
    chk("end_error", {31'd0, error}, {31'd0, !exp_done});
    chk("end_cpu_hold", {31'd0, cpu_hold}, {31'd0, !exp_done});
    chk("end_write_count", wr_cnt, exp_writes);
    chk("end_pending_writes", exp_q.size(), 32'd0);
    byte_in = 8'hA5;
    byte_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("end_byte_ready", {31'd0, byte_ready}, 32'd0);
    end
    byte_valid = 1'b0;
  endtask

  // Reference: image of n words from img_q; n > MAXW is rejected after the length field.
  task automatic run_image(input logic [31:0] n, input bit bad_csum, input int maxgap);
    logic [31:0] sum, w;
    bit          exp_done;
    sum = 32'd0;
    bytes_q.delete();
    for (int k = 0; k < 4; k++) bytes_q.push_back(n[8*k +: 8]);
    exp_done = (n <= 32'(MAXW));
    if (exp_done) begin
      for (int i = 0; i < int'(n); i++) begin
        w = img_q[i];
        exp_q.push_back('{a: BASE + 32'(4 * i), d: w});
        sum += w;
        for (int k = 0; k < 4; k++) bytes_q.push_back(w[8*k +: 8]);
      end
`ifdef CHECKSUM_EN
      if (bad_csum) begin
        sum = sum ^ 32'd1;
        exp_done = 1'b0;
      end
      for (int k = 0; k < 4; k++) bytes_q.push_back(sum[8*k +: 8]);
`else
      if (bad_csum) exp_done = exp_done;
`endif
    end
    foreach (bytes_q[i]) put(bytes_q[i], (maxgap == 0) ? 0 : int'($urandom_range(0, maxgap)));
    byte_valid = 1'b0;
    end_check(exp_done, (n <= 32'(MAXW) && exp_done) ? int'(n) : (n <= 32'(MAXW) ? int'(n) : 0));
  endtask

  initial begin
    int n;
    rst = 1'b0;
    byte_in = 8'd0;
    byte_valid = 1'b0;
    @(negedge clk);
    do_reset(2);

    img_q = '{32'h0000_0513, 32'h0010_0593};
    run_image(32'd2, 1'b0, 0);

    do_reset(2);
    run_image(32'd1025, 1'b0, 0);

    // Abort after six bytes, then resend the whole image.
    do_reset(2);
    bytes_q = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h05};
    foreach (bytes_q[i]) put(bytes_q[i], 0);
    do_reset(1);
    chk("abort_no_write", wr_cnt, 32'd0);
    img_q = '{32'h0000_0513, 32'h0010_0593};
    run_image(32'd2, 1'b0, 0);

    for (int t = 0; t < 6; t++) begin
      do_reset(2);
      img_q.delete();
      n = int'($urandom_range(1, 12));
      for (int i = 0; i < n; i++) img_q.push_back($urandom);
      run_image(32'(n), 1'b0, 3);
    end

    do_reset(2);
    img_q.delete();
    run_image(32'd0, 1'b0, 2);

    do_reset(2);
    run_image(32'h8000_0001, 1'b0, 1);

    do_reset(2);
    img_q.delete();
    for (int i = 0; i < MAXW; i++) img_q.push_back($urandom);
    run_image(32'(MAXW), 1'b0, 0);

`ifdef CHECKSUM_EN
    do_reset(2);
    img_q = '{32'h0000_0513, 32'h0010_0593};
    run_image(32'd2, 1'b1, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1);
  end
endmodule
